// File: rtl/sfp_to_ufp_stream_if.sv
// Valid/ready sample stream carrying one fixed-point word per beat.
interface sfp_to_ufp_stream_if #(
  parameter int W = 8
);
  logic [W-1:0] val;
  logic         valid;
  logic         ready;

  modport master (output val, output valid, input ready);
  modport slave  (input val, input valid, output ready);
endinterface

// File: rtl/sfp_to_ufp_stream.sv
// Signed fixed-point to unsigned fixed-point resize stage: floor on fraction, clip or wrap on integer part.
// One cycle accept-to-valid; output reg plus one skid reg, in_ready drops only when both hold data.
module sfp_to_ufp_stream #(
  parameter int IN_IW  = 5,
  parameter int IN_QW  = 4,
  parameter int OUT_IW = 3,
  parameter int OUT_QW = 2,
  parameter int CLIP   = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sfp_to_ufp_stream_if.slave   src,
  sfp_to_ufp_stream_if.master  dst,
  output logic                 out_clip,
  output logic [CNT_W-1:0]     clip_cnt,
  input  logic                 clip_clr,
  output logic                 clip_sticky
);

  localparam int IN_WL  = IN_IW + IN_QW;
  localparam int OUT_WL = OUT_IW + OUT_QW;
  localparam int SHR    = (OUT_QW < IN_QW) ? (IN_QW - OUT_QW) : 0;
  localparam int SHL    = (OUT_QW > IN_QW) ? (OUT_QW - IN_QW) : 0;
  localparam int EXT_WL = IN_WL + SHL;
  // One spare bit above the widest operand guarantees a non-empty discard field holding the sign.
  localparam int VW     = ((EXT_WL > OUT_WL) ? EXT_WL : OUT_WL) + 1;

  if (OUT_WL < 1) begin : g_bad_out_wl
    $error("sfp_to_ufp_stream: output word length must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("sfp_to_ufp_stream: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state;
  logic [OUT_WL-1:0]   out_val;
  logic [OUT_WL-1:0]   skid_val;
  logic                skid_clip;
  logic                out_vld;
  logic                in_rdy;

  logic signed [VW-1:0] ext;
  logic signed [VW-1:0] v;
  logic [OUT_WL-1:0]    conv_val;
  logic                 conv_evt;
  logic                 accept;
  logic                 emit;

  assign ext = VW'(signed'(src.val));
  assign v   = (ext >>> SHR) <<< SHL;

  always_comb begin
    conv_evt = |v[VW-1:OUT_WL];
    conv_val = v[OUT_WL-1:0];
    if (CLIP != 0 && conv_evt) begin
      conv_val = v[VW-1] ? '0 : '1;
    end
  end

  assign accept    = src.valid && in_rdy;
  assign emit      = out_vld && dst.ready;
  assign src.ready = in_rdy;
  assign dst.val   = out_val;
  assign dst.valid = out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_val   <= '0;
      out_clip  <= 1'b0;
      skid_val  <= '0;
      skid_clip <= 1'b0;
      out_vld   <= 1'b0;
      in_rdy    <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_val  <= conv_val;
            out_clip <= conv_evt;
            out_vld  <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            out_val  <= conv_val;
            out_clip <= conv_evt;
          end else if (accept) begin
            skid_val  <= conv_val;
            skid_clip <= conv_evt;
            in_rdy    <= 1'b0;
            state     <= FULL;
          end else if (emit) begin
            out_vld <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_val  <= skid_val;
            out_clip <= skid_clip;
            in_rdy   <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          state   <= EMPTY;
        end
      endcase
    end
  end

  // Events are counted at accept time, so a sample sitting in the skid reg is already counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt    <= '0;
      clip_sticky <= 1'b0;
    end else if (clip_clr) begin
      clip_cnt    <= CNT_W'(accept && conv_evt);
      clip_sticky <= accept && conv_evt;
    end else if (accept && conv_evt) begin
      if (clip_cnt != '1) begin
        clip_cnt <= clip_cnt + CNT_W'(1);
      end
      clip_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfp_to_ufp_stream.sv
// Directed bench: sfp(5,4) -> ufp(3,2) with saturating, wrapping and 2-bit-counter instances fed identically.
module tb_sfp_to_ufp_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  in_val;
  logic        in_vld;
  logic        out_rdy;
  logic        clr;

  logic        clip_sat, clip_wrap, clip_c2;
  logic [15:0] cnt_sat, cnt_wrap;
  logic [1:0]  cnt_c2;
  logic        sticky_sat, sticky_wrap, sticky_c2;

  int total = 0;
  int bad   = 0;

  logic [8:0] cv_in   [0:3] = '{9'h028, 9'h027, 9'h0A0, 9'h1F0};
  logic [4:0] cv_sat  [0:3] = '{5'h0A, 5'h09, 5'h1F, 5'h00};
  logic [4:0] cv_wrap [0:3] = '{5'h0A, 5'h09, 5'h08, 5'h1C};
  logic       cv_clip [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] cv_cnt [0:3] = '{16'd0, 16'd0, 16'd1, 16'd2};

  always #5 clk = ~clk;

  sfp_to_ufp_stream_if #(.W(9)) in_sat ();
  sfp_to_ufp_stream_if #(.W(9)) in_wrap ();
  sfp_to_ufp_stream_if #(.W(9)) in_c2 ();
  sfp_to_ufp_stream_if #(.W(5)) out_sat ();
  sfp_to_ufp_stream_if #(.W(5)) out_wrap ();
  sfp_to_ufp_stream_if #(.W(5)) out_c2 ();

  assign in_sat.val  = in_val;
  assign in_sat.valid = in_vld;
  assign in_wrap.val = in_val;
  assign in_wrap.valid = in_vld;
  assign in_c2.val   = in_val;
  assign in_c2.valid = in_vld;
  assign out_sat.ready  = out_rdy;
  assign out_wrap.ready = out_rdy;
  assign out_c2.ready   = out_rdy;

  sfp_to_ufp_stream #(.CLIP(1), .CNT_W(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .src(in_sat), .dst(out_sat),
    .out_clip(clip_sat), .clip_cnt(cnt_sat), .clip_clr(clr), .clip_sticky(sticky_sat)
  );

  sfp_to_ufp_stream #(.CLIP(0), .CNT_W(16)) u_wrap (
    .clk(clk), .rst_n(rst_n), .src(in_wrap), .dst(out_wrap),
    .out_clip(clip_wrap), .clip_cnt(cnt_wrap), .clip_clr(clr), .clip_sticky(sticky_wrap)
  );

  sfp_to_ufp_stream #(.CLIP(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .src(in_c2), .dst(out_c2),
    .out_clip(clip_c2), .clip_cnt(cnt_c2), .clip_clr(clr), .clip_sticky(sticky_c2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; clr = 1'b0; in_val = '0;
    #12;
    total++;
    if ({out_sat.valid, in_sat.ready, out_sat.val, clip_sat} !== {1'b0, 1'b1, 5'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b ready=%b val=%h clip=%b exp 0 1 00 0",
               out_sat.valid, in_sat.ready, out_sat.val, clip_sat);
    end
    total++;
    if ({cnt_sat, sticky_sat, cnt_c2} !== {16'd0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_counters got cnt=%0d sticky=%b cnt2=%0d exp 0 0 0", cnt_sat, sticky_sat, cnt_c2);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (out_sat.valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got valid=%b exp 0", out_sat.valid);
    end
  endtask

  task automatic test_convert();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = cv_in[i];
      in_vld = 1'b1;
      step();
      total++;
      if ({out_sat.valid, out_sat.val, clip_sat} !== {1'b1, cv_sat[i], cv_clip[i]}) begin
        bad++;
        $display("FAIL convert_sat[%0d] got valid=%b val=%h clip=%b exp 1 %h %b",
                 i, out_sat.valid, out_sat.val, clip_sat, cv_sat[i], cv_clip[i]);
      end
      total++;
      if ({out_wrap.valid, out_wrap.val, clip_wrap} !== {1'b1, cv_wrap[i], cv_clip[i]}) begin
        bad++;
        $display("FAIL convert_wrap[%0d] got valid=%b val=%h clip=%b exp 1 %h %b",
                 i, out_wrap.valid, out_wrap.val, clip_wrap, cv_wrap[i], cv_clip[i]);
      end
      total++;
      if (cnt_sat !== cv_cnt[i] || cnt_wrap !== cv_cnt[i]) begin
        bad++;
        $display("FAIL convert_cnt[%0d] got sat=%0d wrap=%0d exp %0d", i, cnt_sat, cnt_wrap, cv_cnt[i]);
      end
    end
    in_vld = 1'b0;
    step();
    total++;
    if ({out_sat.valid, sticky_sat, sticky_wrap, cnt_c2} !== {1'b0, 1'b1, 1'b1, 2'd2}) begin
      bad++;
      $display("FAIL convert_drain got valid=%b sticky=%b/%b cnt2=%0d exp 0 1/1 2",
               out_sat.valid, sticky_sat, sticky_wrap, cnt_c2);
    end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0; in_vld = 1'b1; in_val = 9'h028;
    step();
    total++;
    if ({out_sat.valid, out_sat.val, in_sat.ready} !== {1'b1, 5'h0A, 1'b1}) begin
      bad++;
      $display("FAIL bp_first got valid=%b val=%h ready=%b exp 1 0a 1", out_sat.valid, out_sat.val, in_sat.ready);
    end
    in_val = 9'h027;
    step();
    total++;
    if ({out_sat.val, in_sat.ready} !== {5'h0A, 1'b0}) begin
      bad++;
      $display("FAIL bp_full got val=%h ready=%b exp 0a 0", out_sat.val, in_sat.ready);
    end
    in_val = 9'h008;
    step();
    step();
    total++;
    if ({out_sat.valid, out_sat.val, in_sat.ready} !== {1'b1, 5'h0A, 1'b0}) begin
      bad++;
      $display("FAIL bp_hold got valid=%b val=%h ready=%b exp 1 0a 0", out_sat.valid, out_sat.val, in_sat.ready);
    end
    out_rdy = 1'b1;
    step();
    total++;
    if ({out_sat.valid, out_sat.val, in_sat.ready} !== {1'b1, 5'h09, 1'b1}) begin
      bad++;
      $display("FAIL bp_skid_out got valid=%b val=%h ready=%b exp 1 09 1", out_sat.valid, out_sat.val, in_sat.ready);
    end
    step();
    total++;
    if ({out_sat.valid, out_sat.val} !== {1'b1, 5'h02}) begin
      bad++;
      $display("FAIL bp_third got valid=%b val=%h exp 1 02", out_sat.valid, out_sat.val);
    end
    in_vld = 1'b0;
    step();
    total++;
    if (out_sat.valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got valid=%b exp 0", out_sat.valid);
    end
  endtask

  task automatic test_counter();
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if ({cnt_sat, sticky_sat, cnt_c2, sticky_c2} !== {16'd0, 1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL cnt_clear got cnt=%0d sticky=%b cnt2=%0d sticky2=%b exp 0 0 0 0",
               cnt_sat, sticky_sat, cnt_c2, sticky_c2);
    end
    out_rdy = 1'b1; in_vld = 1'b1; in_val = 9'h0A0;
    repeat (5) step();
    total++;
    if ({cnt_c2, sticky_c2, clip_c2, cnt_sat} !== {2'd3, 1'b1, 1'b1, 16'd5}) begin
      bad++;
      $display("FAIL cnt_saturate got cnt2=%0d sticky2=%b clip2=%b cnt=%0d exp 3 1 1 5",
               cnt_c2, sticky_c2, clip_c2, cnt_sat);
    end
    clr = 1'b1;
    step();
    clr = 1'b0; in_vld = 1'b0;
    total++;
    if ({cnt_c2, cnt_sat, sticky_sat} !== {2'd1, 16'd1, 1'b1}) begin
      bad++;
      $display("FAIL cnt_clr_with_event got cnt2=%0d cnt=%0d sticky=%b exp 1 1 1", cnt_c2, cnt_sat, sticky_sat);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if ({cnt_sat, sticky_sat} !== {16'd0, 1'b0}) begin
      bad++;
      $display("FAIL cnt_clr_alone got cnt=%0d sticky=%b exp 0 0", cnt_sat, sticky_sat);
    end
  endtask

  task automatic test_reset_full();
    out_rdy = 1'b0; in_vld = 1'b1; in_val = 9'h0A0;
    step();
    in_val = 9'h028;
    step();
    total++;
    if ({in_sat.ready, cnt_sat} !== {1'b0, 16'd1}) begin
      bad++;
      $display("FAIL rf_full got ready=%b cnt=%0d exp 0 1", in_sat.ready, cnt_sat);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_sat.valid, in_sat.ready, out_sat.val, clip_sat, cnt_sat, sticky_sat} !==
        {1'b0, 1'b1, 5'h00, 1'b0, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL rf_async got valid=%b ready=%b val=%h clip=%b cnt=%0d sticky=%b exp 0 1 00 0 0 0",
               out_sat.valid, in_sat.ready, out_sat.val, clip_sat, cnt_sat, sticky_sat);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    #2 rst_n = 1'b1;
    step();
    step();
    total++;
    if (out_sat.valid !== 1'b0) begin
      bad++;
      $display("FAIL rf_no_stale got valid=%b exp 0", out_sat.valid);
    end
    in_vld = 1'b1; in_val = 9'h028;
    step();
    in_vld = 1'b0;
    total++;
    if ({out_sat.valid, out_sat.val} !== {1'b1, 5'h0A}) begin
      bad++;
      $display("FAIL rf_resume got valid=%b val=%h exp 1 0a", out_sat.valid, out_sat.val);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_backpressure();
    test_counter();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
